// File: rtl/vector_stream_reader_pkg.sv
// Shared types and defaults for the vector stream reader.
// FSM state encoding and default DWIDTH/NUM/IDXW values.
package vector_stream_reader_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int NUM_DEF    = 10;
  localparam int IDXW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/vector_argmax_tracker.sv
// Running signed maximum over streamed words; ties keep lower index.
// Ports: clk, rst, xfer/first/last qualifiers, idx, data -> max_idx, max_val.
module vector_argmax_tracker #(
  parameter int DWIDTH = 32,
  parameter int IDXW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     xfer,
  input  logic                     first,
  input  logic                     last,
  input  logic [IDXW-1:0]          idx,
  input  logic signed [DWIDTH-1:0] data,
  output logic [IDXW-1:0]          max_idx,
  output logic signed [DWIDTH-1:0] max_val
);

  logic signed [DWIDTH-1:0] run_val;
  logic [IDXW-1:0]          run_idx;
  logic signed [DWIDTH-1:0] nxt_val;
  logic [IDXW-1:0]          nxt_idx;
  logic                     take;

  always_comb begin
    take    = first || (data > run_val);
    nxt_idx = take ? idx  : run_idx;
    nxt_val = take ? data : run_val;
  end

  // Results latch on the last transfer so they are
  // already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_val <= '0;
      run_idx <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (xfer) begin
      run_val <= nxt_val;
      run_idx <= nxt_idx;
      if (last) begin
        max_val <= nxt_val;
        max_idx <= nxt_idx;
      end
    end
  end

endmodule

// File: rtl/vector_stream_reader.sv
// Captures a NUM-word vector on load, streams it out over valid/ready.
// Ports: clk, rst, load, in_vec, out_*, busy, done, max_idx, max_val.
// VECTOR_STREAM_ARGMAX_EN adds the argmax tracker; else max_* read 0.
module vector_stream_reader
  import vector_stream_reader_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NUM    = NUM_DEF,
  parameter int IDXW   = IDXW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NUM*DWIDTH-1:0]    in_vec,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [IDXW-1:0]          out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [IDXW-1:0]          max_idx,
  output logic signed [DWIDTH-1:0] max_val
);

  state_t state, state_n;

  logic signed [DWIDTH-1:0] mem [NUM];
  logic [IDXW-1:0]          ptr;
  logic                     xfer;
  logic                     last;

  assign xfer = out_valid && out_ready;
  assign last = (ptr == IDXW'(NUM-1));

  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    unique case (state)
      IDLE: begin
        if (load) state_n = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = ptr;
        out_data  = mem[ptr];
        if (out_ready && last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      for (int k = 0; k < NUM; k++)
        mem[k] <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && load) begin
        ptr <= '0;
        for (int k = 0; k < NUM; k++)
          mem[k] <= in_vec[k*DWIDTH +: DWIDTH];
      end else if (xfer && !last) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

`ifdef VECTOR_STREAM_ARGMAX_EN
  vector_argmax_tracker #(
    .DWIDTH (DWIDTH),
    .IDXW   (IDXW)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .xfer    (xfer),
    .first   (ptr == '0),
    .last    (last),
    .idx     (ptr),
    .data    (out_data),
    .max_idx (max_idx),
    .max_val (max_val)
  );
`else
  assign max_idx = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_vector_stream_reader.sv
// Randomised scoreboard bench for vector_stream_reader.
// Stimulus pushes expected words/argmax; a negedge monitor checks them.
module tb_vector_stream_reader;

  localparam int DW  = 32;
  localparam int NUM = 10;
  localparam int IW  = 4;

  logic                 clk = 0;
  logic                 rst;
  logic                 load;
  logic [NUM*DW-1:0]    in_vec;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        max_idx;
  logic signed [DW-1:0] max_val;

  vector_stream_reader #(
    .DWIDTH (DW),
    .NUM    (NUM),
    .IDXW   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .in_vec    (in_vec),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .max_idx   (max_idx),
    .max_val   (max_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        mq[$];
  exp_t        cur;
  logic [31:0] vw [NUM];
  int          nchk  = 0;
  int          nfail = 0;
  logic        exp_done = 0;
  logic        after_rst = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      mq.delete();
      cur.idx   = 0;
      cur.data  = 0;
      exp_done  = 0;
      after_rst = 1;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done && mq.size() > 0)
        cur = mq.pop_front();
      exp_done = 0;
      chk("max_idx", 32'(max_idx), cur.idx);
      chk("max_val", max_val, cur.data);
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      if (after_rst) begin
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_data", out_data, 0);
        after_rst = 0;
      end
      if (out_valid && q.size() > 0) begin
        chk("out_idx", 32'(out_idx), q[0].idx);
        chk("out_data", out_data, q[0].data);
        if (out_ready) begin
          e = q.pop_front();
          if (e.idx == NUM-1) exp_done = 1;
        end
      end
    end
  end

  // mode 0: ready=1; 1: stall at idx 3 for 5 cycles;
  // 2: random ready plus ignored loads; 3: rst at idx 5
  task automatic run_vector(input int mode);
    exp_t e;
    exp_t m;
    int   cyc;
    int   held;
    for (int k = 0; k < NUM; k++)
      in_vec[k*DW +: DW] = vw[k];
    load = 1;
    @(posedge clk); #1;
    load = 0;
    in_vec = {NUM{$urandom()}};
    m.idx  = 0;
    m.data = 0;
    for (int k = 0; k < NUM; k++) begin
      e.idx  = k;
      e.data = vw[k];
      q.push_back(e);
`ifdef VECTOR_STREAM_ARGMAX_EN
      if (k == 0 || $signed(vw[k]) > $signed(m.data)) begin
        m.idx  = k;
        m.data = vw[k];
      end
`endif
    end
    mq.push_back(m);
    cyc  = 0;
    held = 0;
    while (q.size() > 0) begin
      if (mode == 0) begin
        out_ready = 1;
      end else if (mode == 1) begin
        out_ready = !(q[0].idx == 3 && held < 5);
        if (!out_ready) held++;
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
        load      = ($urandom_range(0, 3) == 0);
        in_vec    = '1;
      end else begin
        out_ready = 1;
        if (q[0].idx == 5) begin
          out_ready = 0;
          rst = 1;
          @(posedge clk); #1;
          rst = 0;
          return;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 500) begin
        nchk++;
        nfail++;
        $display("FAIL timeout: %0d words left, need 0",
                 q.size());
        q.delete();
        return;
      end
    end
    load   = 1'($urandom_range(0, 1));
    in_vec = '1;
    @(posedge clk); #1;
    load = 0;
  endtask

  initial begin
    rst       = 1;
    load      = 0;
    out_ready = 0;
    in_vec    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NUM; k++) vw[k] = 32'(k*100);
    run_vector(0);
    run_vector(1);
    run_vector(2);
    for (int k = 0; k < NUM; k++) vw[k] = 32'(k*100 + 7);
    run_vector(3);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NUM; k++) vw[k] = 32'(k*100);
    run_vector(0);
    for (int k = 0; k < NUM; k++)
      vw[k] = k[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
    run_vector(0);
    for (int k = 0; k < NUM; k++) vw[k] = 0;
    vw[0] = -5; vw[1] = 7; vw[2] = 3;
    vw[3] = 7;  vw[4] = -100;
    run_vector(2);
    for (int k = 0; k < NUM; k++) vw[k] = -50;
    vw[0] = -9; vw[1] = -2; vw[2] = -4;
    run_vector(0);
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NUM; k++)
        vw[k] = (r % 3 == 0) ? 32'($urandom_range(0, 3))
                             : $urandom();
      run_vector(r % 3 == 1 ? 1 : 2);
    end
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
